// File: rtl/tmds_decoder.sv
// tmds_decoder: receive-side TMDS channel decoder for one colour channel.
// Stage 1 registers the deserializer word. An alignment FSM steers bitslip
// until control-token runs appear. Stage 2 registers the decoded
// byte/de/c0/c1, which are held at zero while not aligned.
// Optional build macro: TMDS_ERR_CHECK_EN adds the q[8] encoding-rule check
// that drives err. Without the macro, err is tied to 0.
module tmds_decoder #(
  parameter int LOCK_CNT   = 8,
  parameter int SEARCH_WIN = 2048,
  parameter int SLIP_WAIT  = 16
) (
  input  logic       clk_1x,
  input  logic       sys_rst_n,
  input  logic [9:0] tmds_in,
  output logic       bitslip,
  output logic       aligned,
  output logic [7:0] data_out,
  output logic       de,
  output logic       c0,
  output logic       c1,
  output logic       err
);

  localparam int CW = $clog2((SEARCH_WIN > SLIP_WAIT) ? SEARCH_WIN : SLIP_WAIT);
  localparam int RW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_WAIT, ST_LOCKED} state_t;

  logic [9:0]    r_tmds;
  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [RW-1:0] r_run_cnt, w_run_cnt_next;
  logic          r_run_hit, w_run_hit_next;
  logic          r_bitslip, w_bitslip_next;
  logic          r_aligned;
  logic          w_token;
  logic [1:0]    w_tok_ctl;
  logic          w_win_end, w_wait_end;
  logic [7:0]    w_m, w_d;
  logic [7:0]    r_data;
  logic          r_de, r_c0, r_c1;

  // Stage 1: capture the raw deserializer word
  always_ff @(posedge clk_1x or negedge sys_rst_n) begin
    if (!sys_rst_n) r_tmds <= '0;
    else            r_tmds <= tmds_in;
  end

  // Control-token recognition and its c1c0 value
  always_comb begin
    w_token   = 1'b1;
    w_tok_ctl = 2'b00;
    case (r_tmds)
      10'h354: w_tok_ctl = 2'b00;
      10'h0AB: w_tok_ctl = 2'b01;
      10'h154: w_tok_ctl = 2'b10;
      10'h2AB: w_tok_ctl = 2'b11;
      default: w_token   = 1'b0;
    endcase
  end

  // Data decode: undo the optional inversion, then the XOR/XNOR chain
  assign w_m    = r_tmds[9] ? ~r_tmds[7:0] : r_tmds[7:0];
  assign w_d[0] = w_m[0];
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_dec
      assign w_d[gi] = r_tmds[8] ? (w_m[gi] ^ w_m[gi-1]) : ~(w_m[gi] ^ w_m[gi-1]);
    end
  endgenerate

  // Alignment FSM next state, window/settle counter and bitslip request
  always_comb begin
    w_state_next   = r_state;
    w_bitslip_next = 1'b0;
    w_win_end      = (r_cnt == CW'(SEARCH_WIN - 1));
    w_wait_end     = (r_cnt == CW'(SLIP_WAIT - 1));
    case (r_state)
      ST_SEARCH: begin
        // a qualifying run wins over a coincident window expiry
        if (r_run_hit) begin
          w_state_next = ST_LOCKED;
        end else if (w_win_end) begin
          w_state_next   = ST_WAIT;
          w_bitslip_next = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_wait_end) w_state_next = ST_SEARCH;
      end
      ST_LOCKED: begin
        if (!r_run_hit && w_win_end) w_state_next = ST_SEARCH;
      end
      default: w_state_next = ST_SEARCH;
    endcase
    if ((w_state_next != r_state) || r_run_hit) w_cnt_next = '0;
    else                                        w_cnt_next = r_cnt + 1'b1;
  end

  // Token run counter; r_run_hit marks the cycle the run reaches LOCK_CNT
  always_comb begin
    w_run_cnt_next = '0;
    w_run_hit_next = 1'b0;
    if (w_token && (r_state != ST_WAIT) && (w_state_next != ST_WAIT)) begin
      if (r_run_cnt == RW'(LOCK_CNT)) w_run_cnt_next = r_run_cnt;
      else                            w_run_cnt_next = r_run_cnt + 1'b1;
      w_run_hit_next = (r_run_cnt == RW'(LOCK_CNT - 1));
    end
  end

  // Alignment state, counters, bitslip pulse and aligned flag
  always_ff @(posedge clk_1x or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_SEARCH;
      r_cnt     <= '0;
      r_run_cnt <= '0;
      r_run_hit <= 1'b0;
      r_bitslip <= 1'b0;
      r_aligned <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_run_cnt <= w_run_cnt_next;
      r_run_hit <= w_run_hit_next;
      r_bitslip <= w_bitslip_next;
      r_aligned <= (w_state_next == ST_LOCKED);
    end
  end

  // Stage 2: decoded outputs, forced to zero until aligned; c0/c1 hold on data
  always_ff @(posedge clk_1x or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_data <= '0;
      r_de   <= 1'b0;
      r_c0   <= 1'b0;
      r_c1   <= 1'b0;
    end else if (!r_aligned) begin
      r_data <= '0;
      r_de   <= 1'b0;
      r_c0   <= 1'b0;
      r_c1   <= 1'b0;
    end else if (w_token) begin
      r_data <= '0;
      r_de   <= 1'b0;
      r_c0   <= w_tok_ctl[0];
      r_c1   <= w_tok_ctl[1];
    end else begin
      r_data <= w_d;
      r_de   <= 1'b1;
    end
  end

`ifdef TMDS_ERR_CHECK_EN
  logic [3:0] w_ones;
  logic       w_q8_exp;
  logic       r_err;

  // q[8] the encoder would have chosen for the decoded byte
  always_comb begin
    w_ones   = 4'($countones(w_d));
    w_q8_exp = (w_ones < 4'd4) || ((w_ones == 4'd4) && w_d[0]);
  end

  // Flag a data word whose q[8] disagrees, in step with data_out
  always_ff @(posedge clk_1x or negedge sys_rst_n) begin
    if (!sys_rst_n) r_err <= 1'b0;
    else            r_err <= r_aligned && !w_token && (r_tmds[8] != w_q8_exp);
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign bitslip  = r_bitslip;
  assign aligned  = r_aligned;
  assign data_out = r_data;
  assign de       = r_de;
  assign c0       = r_c0;
  assign c1       = r_c1;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: scoreboard bench for tmds_decoder with a short search window.
// Expected outputs are pushed when a word is driven and compared two edges later.
module tb_tmds_decoder;

  localparam int LOCK_CNT   = 8;
  localparam int SEARCH_WIN = 64;
  localparam int SLIP_WAIT  = 16;

  // Scoreboard entry modes
  localparam int M_SKIP  = 0;
  localparam int M_GATED = 1;
  localparam int M_DEC   = 2;

  logic       clk_1x    = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [9:0] tmds_in   = '0;
  logic       bitslip, aligned, de, c0, c1, err;
  logic [7:0] data_out;

  always #5 clk_1x = ~clk_1x;

  tmds_decoder #(
    .LOCK_CNT  (LOCK_CNT),
    .SEARCH_WIN(SEARCH_WIN),
    .SLIP_WAIT (SLIP_WAIT)
  ) dut (
    .clk_1x   (clk_1x),
    .sys_rst_n(sys_rst_n),
    .tmds_in  (tmds_in),
    .bitslip  (bitslip),
    .aligned  (aligned),
    .data_out (data_out),
    .de       (de),
    .c0       (c0),
    .c1       (c1),
    .err      (err)
  );

  typedef struct {
    int         due;
    int         mode;
    logic [9:0] word;
    logic [7:0] data;
    logic       de;
    logic       c0;
    logic       c1;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic m_c0  = 1'b0;
  logic m_c1  = 1'b0;
  logic slip_forbid = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference decode written as a shifted-XOR of the de-inverted word
  function automatic logic [7:0] ref_decode(input logic [9:0] q);
    logic [7:0] m;
    logic [7:0] d;
    m = q[7:0] ^ {8{q[9]}};
    d = m ^ {m[6:0], 1'b0};
    if (!q[8]) d = d ^ 8'hFE;
    return d;
  endfunction

  function automatic logic ref_err(input logic [9:0] q);
    logic [7:0] d;
    int         ones;
    logic       q8_exp;
    d    = ref_decode(q);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    q8_exp = (ones < 4) || ((ones == 4) && d[0]);
`ifdef TMDS_ERR_CHECK_EN
    return q[8] != q8_exp;
`else
    return 1'b0 & (q[8] ^ q8_exp);
`endif
  endfunction

  function automatic logic is_token(input logic [9:0] q);
    return (q == 10'h354) || (q == 10'h0AB) || (q == 10'h154) || (q == 10'h2AB);
  endfunction

  function automatic logic [1:0] token_ctl(input logic [9:0] q);
    logic [1:0] c;
    c = 2'b00;
    if (q == 10'h0AB) c = 2'b01;
    if (q == 10'h154) c = 2'b10;
    if (q == 10'h2AB) c = 2'b11;
    return c;
  endfunction

  // Drive one word, queue its expectation, advance one edge, retire due entries
  task automatic step(input logic [9:0] word, input int mode);
    exp_t       e;
    logic [1:0] c;
    e.due  = cyc + 2;
    e.mode = mode;
    e.word = word;
    e.data = 8'h00;
    e.de   = 1'b0;
    e.c0   = 1'b0;
    e.c1   = 1'b0;
    e.err  = 1'b0;
    if (mode == M_GATED) begin
      m_c0 = 1'b0;
      m_c1 = 1'b0;
    end else if (mode == M_DEC) begin
      if (is_token(word)) begin
        c    = token_ctl(word);
        m_c0 = c[0];
        m_c1 = c[1];
      end else begin
        e.data = ref_decode(word);
        e.de   = 1'b1;
        e.err  = ref_err(word);
      end
      e.c0 = m_c0;
      e.c1 = m_c1;
    end
    tmds_in = word;
    sb_q.push_back(e);
    @(posedge clk_1x);
    #1;
    cyc++;
    if (slip_forbid) check_val("no_slip", {31'd0, bitslip}, 32'd0);
    while ((sb_q.size() > 0) && (sb_q[0].due <= cyc)) begin
      e = sb_q.pop_front();
      if (e.mode != M_SKIP) begin
        $display("txn cyc=%0d in=%03h out=%02h de=%0b c1c0=%0b%0b err=%0b (exp %02h %0b %0b%0b %0b)",
                 cyc, e.word, data_out, de, c1, c0, err, e.data, e.de, e.c1, e.c0, e.err);
        check_val("decode", {20'd0, err, c1, c0, de, data_out},
                  {20'd0, e.err, e.c1, e.c0, e.de, e.data});
      end
    end
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    while (is_token(w)) w = 10'($urandom_range(0, 1023));
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int tok_start;
    int fall_cyc;
    int slip_cyc;
    int last_slip;
    int n_slip;

    // Reset with a toggling input: every output must stay low
    for (int i = 0; i < 6; i++) begin
      tmds_in = 10'($urandom_range(0, 1023));
      @(posedge clk_1x);
      #1;
      check_val("rst_out", {21'd0, bitslip, aligned, err, c1, c0, de, data_out}, 32'd0);
    end
    sys_rst_n = 1'b1;
    cyc = 0;
    slip_forbid = 1'b1;

    // Lock on a 0x354 stream: aligned must rise exactly LOCK_CNT+1 edges after the first token
    for (int i = 0; i < 12; i++) begin
      step(10'h354, (i <= LOCK_CNT) ? M_GATED : M_DEC);
      if (i == LOCK_CNT)     check_val("aligned_pre", {31'd0, aligned}, 32'd0);
      if (i == LOCK_CNT + 1) check_val("aligned_rise", {31'd0, aligned}, 32'd1);
    end
    for (int i = 0; i < 4; i++) step(10'h2AB, M_DEC);

    // Directed data words, then random data (c1c0 must hold 11)
    step(10'h100, M_DEC);
    step(10'h2FF, M_DEC);
    step(10'h155, M_DEC);
    step(10'h100, M_DEC);
    for (int i = 0; i < 16; i++) step(rand_data(), M_DEC);

    // Refresh the lock window with further token runs
    for (int i = 0; i < 12; i++) step(10'h154, M_DEC);
    for (int i = 0; i < 8; i++)  step(rand_data(), M_DEC);
    tok_start = cyc + 1;
    for (int i = 0; i < 12; i++) step(10'h354, M_DEC);
    check_val("still_locked", {31'd0, aligned}, 32'd1);

    // Loss of lock: data only, aligned must fall one window after the last run
    fall_cyc = -1;
    for (int i = 0; i < 120 && fall_cyc < 0; i++) begin
      step(10'h100, M_SKIP);
      if (!aligned) fall_cyc = cyc;
    end
    slip_forbid = 1'b0;
    if (fall_cyc < 0) begin
      check_val("lock_drop", {31'd0, aligned}, 32'd0);
    end else begin
      check_val("drop_early", {31'd0, fall_cyc >= tok_start + LOCK_CNT + SEARCH_WIN}, 32'd1);
      check_val("drop_late", {31'd0, fall_cyc <= tok_start + LOCK_CNT + 2 + SEARCH_WIN}, 32'd1);
    end

    // After the drop: outputs gated, first bitslip one full window later
    slip_cyc = -1;
    for (int i = 0; i < 100 && slip_cyc < 0; i++) begin
      step(10'h100, M_GATED);
      if (bitslip) slip_cyc = cyc;
    end
    check_val("first_slip", slip_cyc, fall_cyc + SEARCH_WIN);

    // Slip search on a non-token stream: single pulses every SEARCH_WIN+SLIP_WAIT
    last_slip = slip_cyc;
    n_slip = 0;
    for (int i = 0; i < 3 * (SEARCH_WIN + SLIP_WAIT) + 5; i++) begin
      step(10'h155, M_GATED);
      if (bitslip) begin
        check_val("slip_period", cyc - last_slip, SEARCH_WIN + SLIP_WAIT);
        last_slip = cyc;
        n_slip++;
      end
    end
    check_val("slip_count", n_slip, 3);
    check_val("search_unaligned", {31'd0, aligned}, 32'd0);

    // Asynchronous reset while a bitslip pulse is out drops it at once
    slip_cyc = -1;
    for (int i = 0; i < 200 && slip_cyc < 0; i++) begin
      step(10'h155, M_GATED);
      if (bitslip) slip_cyc = cyc;
    end
    check_val("slip_seen", {31'd0, bitslip}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    check_val("async_rst", {23'd0, bitslip, aligned, de, data_out}, 32'd0);
    sb_q.delete();
    @(posedge clk_1x);
    #1;
    check_val("rst_hold", {21'd0, bitslip, aligned, err, c1, c0, de, data_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Receive-side TMDS channel decoder: the inverse of the transmit path's 8b/10b TMDS encoder. It takes 10-bit parallel words from a per-channel deserializer, finds word alignment by steering the deserializer's bitslip until control-token runs appear, and then decodes each word into an 8-bit pixel byte, a data-enable, and the two control bits. One instance serves one channel (B, G or R), and its outputs feed the pixel capture / frame-buffer write logic.

## Interface
- LOCK_CNT, 8: consecutive control tokens required to declare lock (2..255).
- SEARCH_WIN, 2048: cycles allowed to find a qualifying token run before slipping, or before dropping lock (≥ LOCK_CNT+1).
- SLIP_WAIT, 16: settle cycles after each bitslip pulse (≥1).

Ports:
- clk_1x  in  1  pixel-rate clock; the only clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- tmds_in  in  10  parallel word from the deserializer; bit 0 is the first serial bit.
- bitslip  out  1  one-cycle pulse telling the deserializer to rotate by one bit.
- aligned  out  1  word lock achieved.
- data_out  out  8  decoded byte.
- de  out  1  1 = data period, 0 = control period.
- c0  out  1  control bit 0 (hsync on channel B).
- c1  out  1  control bit 1 (vsync on channel B).
- err  out  1  encoding-rule violation pulse (see Configuration).

## Operation
- Stage 1 registers tmds_in into tmds_r.
- All detection and decoding is combinational from tmds_r. Stage 2 registers the results.
- Control tokens, written as q[9:0] hex:
  - 0x354 → c1c0 = 00
  - 0x0AB → 01
  - 0x154 → 10
  - 0x2AB → 11
- A token decodes to de=0, data_out=0x00, and c0/c1 set from the table.
- Any other word decodes as data, with de=1 and c0/c1 holding their previous values:
  - If q[9]=1, invert q[7:0] to give m; otherwise m=q[7:0].
  - d[0] = m[0].
  - For i = 1..7, d[i] = m[i]^m[i-1] when q[8]=1, and ~(m[i]^m[i-1]) when q[8]=0.
- Alignment FSM states are SEARCH, WAIT and LOCKED. Reset enters SEARCH.
- run_cnt increments on each token in tmds_r and clears on any non-token. It saturates at LOCK_CNT.
- A qualifying run is the cycle in which run_cnt reaches LOCK_CNT.
- win_cnt counts cycles in SEARCH and LOCKED. It clears on every state entry and on every qualifying run.
- SEARCH:
  - A qualifying run moves the FSM to LOCKED.
  - If win_cnt reaches SEARCH_WIN-1 with no run, the FSM pulses bitslip for one cycle and moves to WAIT.
  - If a run and window expiry coincide, the run wins.
- WAIT:
  - Holds for SLIP_WAIT cycles, then returns to SEARCH.
  - run_cnt is held at 0 throughout.
- LOCKED:
  - Each qualifying run restarts the window.
  - If win_cnt reaches SEARCH_WIN-1 with no run, the FSM drops to SEARCH with no bitslip.
- aligned = (state == LOCKED), registered.
- While aligned=0, stage 2 forces data_out=0, de=0, c0=0, c1=0 and err=0.

## Timing
- Reset values: bitslip=0, aligned=0, data_out=0x00, de=0, c0=0, c1=0, err=0. The FSM is in SEARCH and all counters are 0.
- Latency from tmds_in to data_out/de/c0/c1/err is 2 cycles.
- aligned rises LOCK_CNT+1 edges after the first token of a run is sampled by stage 1.
- aligned falls on the edge the FSM leaves LOCKED. Outputs are gated from the following stage-2 update.
- With no tokens present, bitslip pulses exactly once every SEARCH_WIN+SLIP_WAIT cycles.
- bitslip is never asserted in LOCKED or WAIT, except on the single WAIT entry cycle.
- Reset asserted mid-operation clears everything immediately (asynchronously). A pending bitslip is dropped.

## Configuration
- Macro TMDS_ERR_CHECK_EN controls the encoding-rule check.
- Defined:
  - For each data word, recompute the encoder's stage-1 choice from the decoded byte d. The expected q[8] is 1 when popcount(d)<4, or when popcount(d)==4 and d[0]=1; otherwise it is 0.
  - err=1 for the output cycle of any data word whose q[8] differs from that expectation, aligned with data_out.
  - err=0 on tokens.
- Undefined: err is tied to 0 and no check logic is built.

## Test plan
- Reset check: assert reset with tmds_in toggling → all outputs 0, aligned=0.
- Lock and token decode: LOCK_CNT=8, then a continuous 0x354 stream → aligned=1 nine edges after the first token is registered, then de=0, c1c0=00. Then 0x2AB → c1c0=11 two cycles later.
- Data decode:
  - After lock, 0x100 → data_out=0x00, de=1.
  - 0x2FF → 0xFE, de=1.
  - Both cases err=0, 2-cycle latency.
- Slip search: SEARCH_WIN=64, SLIP_WAIT=16, constant 0x155 → bitslip single-cycle pulses at 80-cycle period, aligned stays 0.
- Loss of lock: lock, then 64+ cycles of 0x100 only → aligned falls, outputs forced to 0, bitslip pulses resume after the next window.
- Error check (with TMDS_ERR_CHECK_EN): after lock, 0x155 → data_out=0xFF, de=1, err=1 for one cycle. Without the macro, err stays 0.
